// File: rtl/fp_add_arbiter_pkg.sv
// Shared types for the FP adder arbiter: state encoding, tag record, helpers.
// FP_ADD_ARB_SUB_EN (optional) enables per-requester subtract.
package fp_add_arb_pkg;

  localparam logic [31:0] FP_ZERO = 32'h0;

  localparam int TAG_ID_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/fp_add_arbiter_if.sv
// Requester, adder-slice and response signals of the FP adder arbiter.
// FP_ADD_ARB_SUB_EN adds the req_sub lines.
interface fp_add_arbiter_if
  import fp_add_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
`ifdef FP_ADD_ARB_SUB_EN
  logic [NUM_REQ-1:0]            req_sub;
`endif
  logic                          add_en;
  logic [DATA_WIDTH-1:0]         add_a;
  logic [DATA_WIDTH-1:0]         add_b;
  logic [DATA_WIDTH-1:0]         add_result;
  logic                          rsp_valid;
  logic [ID_W-1:0]               rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          busy;

`ifdef FP_ADD_ARB_SUB_EN
  modport slave (
    input  req_valid, req_a, req_b, req_sub,
    input  add_result,
    output req_ready, add_en, add_a, add_b,
    output rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_sub,
    output add_result,
    input  req_ready, add_en, add_a, add_b,
    input  rsp_valid, rsp_id, rsp_data, busy
  );
`else
  modport slave (
    input  req_valid, req_a, req_b,
    input  add_result,
    output req_ready, add_en, add_a, add_b,
    output rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req_valid, req_a, req_b,
    output add_result,
    input  req_ready, add_en, add_a, add_b,
    input  rsp_valid, rsp_id, rsp_data, busy
  );
`endif

endinterface

// File: rtl/fp_add_arbiter_rr_arbiter.sv
// N-wide round-robin arbiter: search starts at ptr, ptr moves past the winner.
// Shared with other slice controllers; advance gates the pointer update.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic          grant_any,
  output logic [IW-1:0] grant_id
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  int            k;

  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    ptr_d     = ptr_q;
    k         = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr_q) + i) % N;
      if (!grant_any && req[k]) begin
        grant[k]  = 1'b1;
        grant_any = 1'b1;
        grant_id  = IW'(k);
        ptr_d     = (k == N - 1) ? '0 : IW'(k + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (advance && grant_any) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin sharing of one clocked FP adder slice between NUM_REQ requesters.
// FP_ADD_ARB_SUB_EN: req_sub[k] flips operand B sign so the slice computes A-B.
module fp_add_arbiter
  import fp_add_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = clog2(NUM_REQ),
  parameter int ADD_LATENCY = 3
) (
  input logic           clk,
  input logic           rst_n,
  fp_add_arbiter_if.slave bus
);

  localparam int CNT_W = clog2(ADD_LATENCY + 1);
  localparam int LAST  = ADD_LATENCY - 1;

  state_e             state_q;
  state_e             state_d;
  logic               en;
  logic               en_g;
  logic               issue;
  logic               retire;
  logic               drained;
  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  logic [ID_W-1:0]    grant_id;
  tag_t               tag0;
  tag_t               tag_q [1:LAST];
  logic [CNT_W-1:0]   infl_q;
  logic [CNT_W-1:0]   infl_d;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.req_valid),
    .advance   (issue),
    .grant     (grant),
    .grant_any (grant_any),
    .grant_id  (grant_id)
  );

  // A tag reaching the last stage implies add_en is high this cycle.
  assign drained = (infl_q - CNT_W'(tag_q[LAST].valid)) == '0;

  always_comb begin
    state_d = state_q;
    en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          en      = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        en = 1'b1;
        if (!(|bus.req_valid)) begin
          state_d = drained ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        en = 1'b1;
        if (|bus.req_valid) begin
          state_d = ACTIVE;
        end else if (drained) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign en_g          = en && rst_n;
  assign issue         = en_g && grant_any;
  assign retire        = en_g && tag_q[LAST].valid;
  assign bus.add_en    = en_g;
  assign bus.req_ready = issue ? grant : '0;
  assign bus.busy      = state_q != IDLE;

  always_comb begin
    bus.add_a = DATA_WIDTH'(FP_ZERO);
    bus.add_b = DATA_WIDTH'(FP_ZERO);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (issue && grant[i]) begin
        bus.add_a = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
        bus.add_b = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef FP_ADD_ARB_SUB_EN
        if (bus.req_sub[i]) begin
          bus.add_b[DATA_WIDTH-1] = ~bus.add_b[DATA_WIDTH-1];
        end
`endif
      end
    end
  end

  always_comb begin
    tag0       = '0;
    tag0.valid = issue;
    tag0.id    = TAG_ID_W'(grant_id);
  end

  // Tags advance only with the slice so they stay aligned with its registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 1; s <= LAST; s++) begin
        tag_q[s] <= '0;
      end
    end else if (en_g) begin
      tag_q[1] <= tag0;
      for (int s = 2; s <= LAST; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  always_comb begin
    infl_d = infl_q;
    case ({issue, retire})
      2'b10:   infl_d = infl_q + 1'b1;
      2'b01:   infl_d = infl_q - 1'b1;
      default: infl_d = infl_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_q <= '0;
    end else begin
      infl_q <= infl_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
    end else begin
      bus.rsp_valid <= retire;
      if (retire) begin
        bus.rsp_id   <= tag_q[LAST].id[ID_W-1:0];
        bus.rsp_data <= bus.add_result;
      end
    end
  end

endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
- Shares one clocked floating-point adder slice (operand registers, adder, output register, common enable) between NUM_REQ requesters.
- Round-robin arbitration with at most one issue per cycle.
- Drives the slice's enable and operands, and tracks each in-flight operation with a tag pipeline.
- Returns every result with the ID of the requester that issued it.
- Sits between FFT butterfly/twiddle sequencers and the single shared adder instance.

Parameters:
- DATA_WIDTH, 32: IEEE-754 single-precision operand/result width.
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 2: requester ID width, equal to clog2(NUM_REQ).
- ADD_LATENCY, 3: cycles from adder-slice input sample to valid result on add_result (input reg + adder + output reg).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester operation request
- req_ready  out  NUM_REQ  per-requester grant, one-hot or zero, combinational
- req_a  in  NUM_REQ*DATA_WIDTH  operand A, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_b  in  NUM_REQ*DATA_WIDTH  operand B, same packing as req_a
- add_en  out  1  enable to adder slice
- add_a  out  DATA_WIDTH  operand A to adder slice
- add_b  out  DATA_WIDTH  operand B to adder slice
- add_result  in  DATA_WIDTH  adder slice output
- rsp_valid  out  1  result valid, single-cycle pulse
- rsp_id  out  ID_W  originating requester
- rsp_data  out  DATA_WIDTH  sum
- busy  out  1  state is not IDLE

Behaviour:
- Clock and reset: clock clk; reset rst_n, asynchronous, active-low.
- Reset values:
  - state = IDLE, rr_ptr = 0, tag pipe all invalid, in-flight counter = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0.
  - add_en = 0, req_ready = 0.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i] are both high in the same cycle.
  - req_valid must be held with stable operands until the transfer.
  - No response backpressure; rsp_valid is always consumed.
- Arbitration:
  - Round-robin. Search starts at rr_ptr and wraps modulo NUM_REQ.
  - The first valid requester is granted.
  - After a grant to requester k, rr_ptr = (k+1) mod NUM_REQ.
  - With no valid requests, rr_ptr holds and req_ready = 0.
- Issue:
  - On a grant, add_a/add_b are muxed from the granted requester and add_en = 1 in the same cycle.
  - On a bubble cycle (add_en = 1, no grant), add_a = add_b = 0.
- Tag pipe:
  - ADD_LATENCY stages of {valid, id}. Shifts every cycle that add_en = 1.
  - Stage 0 loads {grant_any, grant_id}.
  - In-flight counter is +1 on issue and −1 on retire; both in the same cycle leaves it unchanged.
- Response:
  - When the last stage is valid and add_en = 1: rsp_valid = 1, rsp_id = tag id, rsp_data = add_result, all registered.
  - Latency: transfer in cycle T gives rsp_valid in cycle T+ADD_LATENCY.
  - Results are returned in issue order.
- States:
  - IDLE: add_en = 0. Any req_valid → ACTIVE, and the grant is issued in that same cycle.
  - ACTIVE: add_en = 1. No req_valid with in-flight > 0 → DRAIN. No req_valid with in-flight == 0 → IDLE.
  - DRAIN: add_en = 1 with bubbles. A new req_valid is granted immediately → ACTIVE. in-flight == 0 after retire → IDLE.
- add_en is never deasserted while any tag is valid. Reason: the slice output register holds when its enable is low, so dropping add_en would corrupt latency tracking.
- Reset mid-operation: all in-flight operations are discarded and no rsp_valid pulses. Requesters must re-issue.
- Boundary cases:
  - All NUM_REQ requesters continuously valid: each receives exactly one grant per NUM_REQ cycles.
  - rr_ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
- Macro: FP_ADD_ARB_SUB_EN.
- Defined:
  - Adds input port req_sub (NUM_REQ bits).
  - When granted requester k has req_sub[k] = 1, add_b = {~req_b_k[31], req_b_k[30:0]}, so the slice computes A − B.
  - The sign flip is not applied on bubbles.
- Undefined: no req_sub port; addition only.

Decomposition:
- Package fp_add_arb_pkg holds:
  - FP_ZERO constant (32'h0).
  - State encoding typedef {IDLE, ACTIVE, DRAIN}.
  - Tag struct {valid, id}.
  - clog2 helper.
- One natural sub-module, rr_arbiter: NUM_REQ-wide round-robin grant plus pointer update, reusable by the multiplier controller.

Test Plan:
- Single op: req 0 sends 1.0 (0x3F800000) + 2.0 (0x40000000) at T → rsp_valid at T+3 with rsp_id = 0, rsp_data = 0x40400000; then busy = 0 and add_en = 0.
- All 4 requesters held valid for 8 cycles → grant order 0,1,2,3,0,1,2,3; 8 responses with IDs in the same order, each one cycle apart.
- Requester 2 alone, then requesters 1 and 3 together with rr_ptr = 3 → requester 3 is granted first, then requester 1.
- Gap during drain: issue at T, new request at T+1 → no IDLE transition; both results at T+3 and T+4; add_en stays high throughout.
- rst_n asserted at T+1 after an issue at T → no rsp_valid ever; all outputs at reset values immediately (async).
- With FP_ADD_ARB_SUB_EN defined: req_sub[1] = 1, 3.0 − 1.0 → rsp_data = 0x40000000, rsp_id = 1.
